// File: rtl/cpu_bus_bridge.sv
// CPU bus bridge: turns each rising edge of the core's bus strobe into one req/ack peripheral transaction.
// Optional macro CPU_BUS_BRIDGE_TIMEOUT_EN adds a forced completion after TIMEOUT cycles without ack.
module cpu_bus_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_bus_clk,
    input  logic              i_bus_we,
    input  logic [ADDR_W-1:0] i_bus_addr,
    input  logic [DATA_W-1:0] i_bus_wdata,
    output logic [DATA_W-1:0] o_bus_rdata,
    output logic              o_bus_data_ready,
    output logic              o_per_req,
    output logic              o_per_we,
    output logic [ADDR_W-1:0] o_per_addr,
    output logic [DATA_W-1:0] o_per_wdata,
    input  logic [DATA_W-1:0] i_per_rdata,
    input  logic              i_per_ack,
    input  logic              i_clr_status,
    output logic              o_overrun,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    if ((WAIT_STATES < 0) || (WAIT_STATES > 15) || (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_param_check
        $error("cpu_bus_bridge: parameter out of range");
    end

    state_t              state_r, state_s;
    logic [3:0]          wait_cnt_r, wait_cnt_s;
    logic                prev_r;
    logic                armed_r;
    logic                edge_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                ready_r, ready_s;
    logic                req_r, req_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                overrun_r, overrun_s;
    logic                timeout_r, timeout_s;
    logic                tmo_set_s;

`ifdef CPU_BUS_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_L = 16'(TIMEOUT);
    logic [15:0]         tmo_cnt_r, tmo_cnt_s;
`endif

    // armed_r masks the first cycle after reset so a strobe already high is not taken as an edge
    assign edge_s = i_bus_clk & ~prev_r & armed_r;

    // Next-state, latched request fields, read data and sticky flags
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        rdata_s    = rdata_r;
        we_s       = we_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        tmo_set_s  = 1'b0;
`ifdef CPU_BUS_BRIDGE_TIMEOUT_EN
        tmo_cnt_s  = tmo_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    we_s    = i_bus_we;
                    addr_s  = i_bus_addr;
                    wdata_s = i_bus_wdata;
                    if (WAIT_STATES > 0) begin
                        state_s    = ST_SETUP;
                        wait_cnt_s = WS_L;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (wait_cnt_r == 4'd1) begin
                    state_s = ST_ACCESS;
                end else begin
                    wait_cnt_s = wait_cnt_r - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (i_per_ack) begin
                    state_s = ST_DONE;
                    if (!we_r) begin
                        rdata_s = i_per_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
`ifdef CPU_BUS_BRIDGE_TIMEOUT_EN
                    if (tmo_cnt_r == TMO_L) begin
                        state_s   = ST_DONE;
                        tmo_set_s = 1'b1;
                        if (!we_r) begin
                            rdata_s = {DATA_W{1'b1}};
                        end else begin
                            rdata_s = rdata_r;
                        end
                    end else begin
                        tmo_cnt_s = tmo_cnt_r + 16'd1;
                    end
`else
                    state_s = ST_ACCESS;
`endif
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

`ifdef CPU_BUS_BRIDGE_TIMEOUT_EN
        if ((state_r != ST_ACCESS) && (state_s == ST_ACCESS)) begin
            tmo_cnt_s = 16'd0;
        end else begin
            tmo_cnt_s = tmo_cnt_s;
        end
`endif

        // a set event in the same cycle as a clear wins
        if (edge_s && (state_r != ST_IDLE)) begin
            overrun_s = 1'b1;
        end else if (i_clr_status) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end

        if (tmo_set_s) begin
            timeout_s = 1'b1;
        end else if (i_clr_status) begin
            timeout_s = 1'b0;
        end else begin
            timeout_s = timeout_r;
        end

        req_s   = (state_s == ST_ACCESS);
        ready_s = (state_s == ST_DONE);
    end

    // State and registered outputs, all cleared immediately by reset
    always_ff @(posedge i_cpu_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            prev_r     <= 1'b0;
            armed_r    <= 1'b0;
            rdata_r    <= {DATA_W{1'b0}};
            ready_r    <= 1'b0;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            overrun_r  <= 1'b0;
            timeout_r  <= 1'b0;
`ifdef CPU_BUS_BRIDGE_TIMEOUT_EN
            tmo_cnt_r  <= 16'd0;
`endif
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            prev_r     <= i_bus_clk;
            armed_r    <= 1'b1;
            rdata_r    <= rdata_s;
            ready_r    <= ready_s;
            req_r      <= req_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            overrun_r  <= overrun_s;
            timeout_r  <= timeout_s;
`ifdef CPU_BUS_BRIDGE_TIMEOUT_EN
            tmo_cnt_r  <= tmo_cnt_s;
`endif
        end
    end

    assign o_bus_rdata      = rdata_r;
    assign o_bus_data_ready = ready_r;
    assign o_per_req        = req_r;
    assign o_per_we         = we_r;
    assign o_per_addr       = addr_r;
    assign o_per_wdata      = wdata_r;
    assign o_overrun        = overrun_r;
    assign o_timeout        = timeout_r;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: instance a has no wait states, instance b has three.
module tb_cpu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_bus_clk = 1'b0, a_we = 1'b0, a_ack = 1'b0, a_clr = 1'b0;
    logic [31:0] a_addr = 32'd0, a_wdata = 32'd0, a_per_rdata = 32'd0;
    logic [31:0] a_rdata, a_paddr, a_pwdata;
    logic        a_ready, a_req, a_pwe, a_ovr, a_tmo;

    logic        b_bus_clk = 1'b0, b_we = 1'b0, b_ack = 1'b0, b_clr = 1'b0;
    logic [31:0] b_addr = 32'd0, b_wdata = 32'd0, b_per_rdata = 32'd0;
    logic [31:0] b_rdata, b_paddr, b_pwdata;
    logic        b_ready, b_req, b_pwe, b_ovr, b_tmo;

    int total = 0;
    int bad = 0;
    int got;

    always #5 clk = ~clk;

    cpu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0), .TIMEOUT(8)) dut_a (
        .i_cpu_clk(clk), .i_rst(rst_n), .i_bus_clk(a_bus_clk), .i_bus_we(a_we),
        .i_bus_addr(a_addr), .i_bus_wdata(a_wdata), .o_bus_rdata(a_rdata),
        .o_bus_data_ready(a_ready), .o_per_req(a_req), .o_per_we(a_pwe),
        .o_per_addr(a_paddr), .o_per_wdata(a_pwdata), .i_per_rdata(a_per_rdata),
        .i_per_ack(a_ack), .i_clr_status(a_clr), .o_overrun(a_ovr), .o_timeout(a_tmo)
    );

    cpu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(3), .TIMEOUT(8)) dut_b (
        .i_cpu_clk(clk), .i_rst(rst_n), .i_bus_clk(b_bus_clk), .i_bus_we(b_we),
        .i_bus_addr(b_addr), .i_bus_wdata(b_wdata), .o_bus_rdata(b_rdata),
        .o_bus_data_ready(b_ready), .o_per_req(b_req), .o_per_we(b_pwe),
        .o_per_addr(b_paddr), .o_per_wdata(b_pwdata), .i_per_rdata(b_per_rdata),
        .i_per_ack(b_ack), .i_clr_status(b_clr), .o_overrun(b_ovr), .o_timeout(b_tmo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_a_flags", {27'd0, a_ready, a_req, a_pwe, a_ovr, a_tmo}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_a_addr", a_paddr, 32'd0);
        chk("rst_b_flags", {27'd0, b_ready, b_req, b_pwe, b_ovr, b_tmo}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step(); step();

        // read, no wait states, ack in first req cycle
        a_we = 1'b0; a_addr = 32'h0000_1234; a_bus_clk = 1'b1;
        chk("rd0_req_c0", {31'd0, a_req}, 32'd0);
        step();
        chk("rd0_req_c1", {31'd0, a_req}, 32'd1);
        chk("rd0_addr", a_paddr, 32'h0000_1234);
        chk("rd0_we", {31'd0, a_pwe}, 32'd0);
        chk("rd0_ready_c1", {31'd0, a_ready}, 32'd0);
        a_per_rdata = 32'hDEAD_BEEF; a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        chk("rd0_ready_c2", {31'd0, a_ready}, 32'd1);
        chk("rd0_req_c2", {31'd0, a_req}, 32'd0);
        chk("rd0_rdata", a_rdata, 32'hDEAD_BEEF);
        step();
        chk("rd0_ready_c3", {31'd0, a_ready}, 32'd0);
        a_bus_clk = 1'b0;

        // stray ack while idle
        a_per_rdata = 32'h1234_5678; a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        chk("stray_ready1", {31'd0, a_ready}, 32'd0);
        step();
        chk("stray_ready2", {31'd0, a_ready}, 32'd0);
        chk("stray_rdata", a_rdata, 32'hDEAD_BEEF);
        chk("stray_flags", {30'd0, a_ovr, a_tmo}, 32'd0);

        // overrun: second edge during ACCESS, with a clear in the same cycle
        a_addr = 32'h0000_0040; a_bus_clk = 1'b1;
        step();
        a_bus_clk = 1'b0;
        step();
        chk("ovr_req_pre", {31'd0, a_req}, 32'd1);
        a_addr = 32'h0000_0099; a_bus_clk = 1'b1; a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("ovr_set", {31'd0, a_ovr}, 32'd1);
        chk("ovr_addr_kept", a_paddr, 32'h0000_0040);
        a_per_rdata = 32'hA5A5_A5A5; a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        chk("ovr_ready", {31'd0, a_ready}, 32'd1);
        chk("ovr_rdata", a_rdata, 32'hA5A5_A5A5);
        step(); step();
        chk("ovr_single_txn", {30'd0, a_req, a_ready}, 32'd0);
        a_bus_clk = 1'b0; a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("ovr_cleared", {31'd0, a_ovr}, 32'd0);

        // read with no ack: forced completion only with the timeout macro
        a_addr = 32'h0000_0080; a_bus_clk = 1'b1;
        step();
        a_bus_clk = 1'b0;
        chk("tmo_req_rise", {31'd0, a_req}, 32'd1);
        got = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (a_ready) begin
                got = i;
                break;
            end
        end
`ifdef CPU_BUS_BRIDGE_TIMEOUT_EN
        chk("tmo_latency", got, 32'd9);
        chk("tmo_rdata", a_rdata, 32'hFFFF_FFFF);
        chk("tmo_flag", {31'd0, a_tmo}, 32'd1);
        step();
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("tmo_cleared", {31'd0, a_tmo}, 32'd0);
        a_addr = 32'h0000_00C0; a_bus_clk = 1'b1;
        step();
        a_bus_clk = 1'b0;
        step();
`else
        chk("tmo_no_ready", got, 32'd0);
        chk("tmo_flag_off", {31'd0, a_tmo}, 32'd0);
`endif

        // reset in the middle of ACCESS
        chk("rstmid_req_pre", {31'd0, a_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_req", {31'd0, a_req}, 32'd0);
        chk("rstmid_flags", {27'd0, a_ready, a_req, a_pwe, a_ovr, a_tmo}, 32'd0);
        chk("rstmid_rdata", a_rdata, 32'd0);
        chk("rstmid_addr", a_paddr, 32'd0);
        a_bus_clk = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rel_high_no_txn", {30'd0, a_req, a_ready}, 32'd0);
        end
        a_bus_clk = 1'b0;

        // WAIT_STATES=3: read first so a later write can show rdata is left alone
        b_we = 1'b0; b_addr = 32'h0000_0010; b_bus_clk = 1'b1;
        got = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            b_bus_clk = 1'b0;
            if (b_req) begin
                got = i;
                break;
            end
        end
        chk("ws3_rd_req_delay", got, 32'd4);
        b_per_rdata = 32'h1357_9BDF; b_ack = 1'b1;
        step();
        b_ack = 1'b0;
        chk("ws3_rd_ready", {31'd0, b_ready}, 32'd1);
        chk("ws3_rd_rdata", b_rdata, 32'h1357_9BDF);
        step();

        // write 0xA5 to 0xFF00, ack two cycles after req rises
        b_we = 1'b1; b_addr = 32'h0000_FF00; b_wdata = 32'h0000_00A5; b_bus_clk = 1'b1;
        got = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            b_bus_clk = 1'b0;
            if (i == 1) begin
                chk("ws3_wr_we", {31'd0, b_pwe}, 32'd1);
                chk("ws3_wr_addr", b_paddr, 32'h0000_FF00);
                chk("ws3_wr_wdata", b_pwdata, 32'h0000_00A5);
            end
            if (b_req) begin
                got = i;
                break;
            end
        end
        chk("ws3_wr_req_delay", got, 32'd4);
        b_per_rdata = 32'h5555_AAAA;
        step();
        chk("ws3_wr_wait1", {30'd0, b_req, b_ready}, 32'd2);
        step();
        chk("ws3_wr_wait2", {30'd0, b_req, b_ready}, 32'd2);
        b_ack = 1'b1;
        step();
        b_ack = 1'b0;
        chk("ws3_wr_ready", {30'd0, b_req, b_ready}, 32'd1);
        chk("ws3_wr_rdata_kept", b_rdata, 32'h1357_9BDF);
        step();
        chk("ws3_wr_one_pulse", {31'd0, b_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
